pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central hazard/stall scheduler for the 5-stage pipeline.
- Drives the 2-bit stall codes of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold.
- Arbitrates four stall sources: data-memory wait, multi-cycle divide in EX, load-use hazard, taken-branch flush.
- Stall code convention on every register: 2'b00 = load, 2'b01 = flush to bubble, 2'b11 = hold. 2'b10 is also flush in the registers; this block never emits 2'b10.

Parameters:
- DIV_CYCLES, 8, total EX-stage occupancy of a divide in cycles; must be >= 2.
- MEM_TIMEOUT, 64, consecutive memory-wait cycles before mem_timeout pulses; must be >= 1.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- MemtoRegE  input  1  EX-stage instruction is a load
- RegWriteE  input  1  EX-stage instruction writes the register file
- WriteRegE  input  5  EX-stage destination register
- RsD  input  5  ID-stage source register 1
- RtD  input  5  ID-stage source register 2
- PCSrcD  input  1  branch taken, resolved in ID
- div_startE  input  1  EX-stage instruction is a divide
- mem_accM  input  1  MEM-stage instruction accesses data memory
- dmem_ready  input  1  data memory completes the access this cycle
- stallF  output  1  1 = hold PC
- stall_FD  output  2  IF/ID stall code
- stall_DE  output  2  ID/EX stall code
- stall_EM  output  2  EX/MEM stall code
- stall_MW  output  2  MEM/WB stall code
- div_done  output  1  one-cycle pulse on the divide release cycle
- mem_timeout  output  1  one-cycle pulse on a memory-wait timeout
- stall_cycles  output  32  count of cycles with stallF=1; wraps modulo 2^32

Behaviour:
- Stall outputs are combinational from state and inputs. Same-cycle response is required, with no added latency.
- While rst=0, outputs are forced low: all stall codes 00, stallF=0, div_done=0, mem_timeout=0.
- Reset state: state=RUN, div_cnt=0, wait_cnt=0, stall_cycles=0. Reset asserted mid-divide or mid-wait abandons the operation immediately.
- Conditions:
  - mem_stall = mem_accM & !dmem_ready.
  - lu = MemtoRegE & RegWriteE & (WriteRegE!=0) & (WriteRegE==RsD | WriteRegE==RtD).
- Priority, highest first: mem_stall > divide > lu > PCSrcD.
- Output codes by winning source:
  - mem_stall: stallF=1, FD=11, DE=11, EM=11, MW=01.
  - Divide hold: stallF=1, FD=11, DE=11, EM=01, MW=00.
  - lu: stallF=1, FD=11, DE=01, EM=00, MW=00.
  - PCSrcD: stallF=0, FD=01, others 00.
  - None active: all 00, stallF=0.
- FSM has two states, RUN and DIV_BUSY.
- RUN:
  - div_startE=1 is the issue cycle. Apply divide hold (overlaid by mem_stall if active). Load div_cnt=DIV_CYCLES-2. Go to DIV_BUSY next cycle.
  - The issue cycle and FSM transition occur even if mem_stall is active.
- DIV_BUSY:
  - div_cnt decrements every cycle down to 0, then saturates at 0. It keeps decrementing during mem_stall.
  - div_cnt != 0: divide hold applies.
  - div_cnt == 0 and !mem_stall: release cycle. Divide imposes no stall; lu/PCSrcD apply normally. div_done=1. Next state RUN.
  - div_cnt == 0 and mem_stall: mem_stall outputs apply; stay in DIV_BUSY; div_done deferred.
  - Result: with no memory stall, EX holds for exactly DIV_CYCLES-1 cycles, and the divide leaves EX after DIV_CYCLES cycles.
- div_startE is ignored in DIV_BUSY.
- wait_cnt:
  - Increments on each mem_stall cycle; clears on any cycle without mem_stall.
  - mem_timeout pulses in the cycle where wait_cnt transitions to MEM_TIMEOUT.
  - wait_cnt then saturates at MEM_TIMEOUT; no repeat pulse until it clears.
- stall_cycles increments on every clk edge where stallF=1 and rst=1.

Test Plan:
- Load-use: MemtoRegE=1, RegWriteE=1, WriteRegE=5, RsD=5 for one cycle -> stallF=1, FD=11, DE=01, EM=00, MW=00. Repeat with WriteRegE=0 -> all 00.
- Branch vs load-use: PCSrcD=1 alone -> FD=01, stallF=0. PCSrcD=1 together with lu -> lu codes only.
- Divide, DIV_CYCLES=8: div_startE pulse -> 7 consecutive cycles of FD=11, DE=11, EM=01, then a release cycle with all 00 and div_done=1. stall_cycles increases by 7.
- Memory wait: mem_accM=1, dmem_ready=0 for 3 cycles, then 1 -> 3 cycles of FD=11, DE=11, EM=11, MW=01, then 00. Hold dmem_ready=0 for 70 cycles with MEM_TIMEOUT=64 -> mem_timeout pulses once, on the 64th wait cycle.
- Overlap: mem_stall raised as div_cnt reaches 0 and held 4 cycles -> mem_stall codes for those 4 cycles; div_done asserts in the first cycle after dmem_ready=1.
- Reset mid-divide: rst=0 asserted at div_cnt=3 -> outputs 00 immediately. After release, state is RUN and no div_done occurs.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: arbitrates memory wait,
// multi-cycle divide, load-use and taken-branch into per-register stall codes.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES  = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoRegE,
  input  logic        RegWriteE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        PCSrcD,
  input  logic        div_startE,
  input  logic        mem_accM,
  input  logic        dmem_ready,
  output logic        stallF,
  output logic [1:0]  stall_FD,
  output logic [1:0]  stall_DE,
  output logic [1:0]  stall_EM,
  output logic [1:0]  stall_MW,
  output logic        div_done,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  localparam int DCW = $clog2(DIV_CYCLES);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] FLUSH = 2'b01;
  localparam logic [1:0] HOLD  = 2'b11;

  logic [0:0]     state_reg, state_next;
  logic [DCW-1:0] div_cnt_reg, div_cnt_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;

  logic mem_stall, lu, div_issue, div_hold, div_release;

  assign mem_stall = mem_accM & ~dmem_ready;
  assign lu = MemtoRegE & RegWriteE & (WriteRegE != 5'd0) &
              ((WriteRegE == RsD) | (WriteRegE == RtD));

  assign div_issue   = (state_reg == RUN) & div_startE;
  assign div_hold    = div_issue | ((state_reg == DIV_BUSY) & (div_cnt_reg != '0));
  assign div_release = (state_reg == DIV_BUSY) & (div_cnt_reg == '0) & ~mem_stall;

  // Priority encode the winning source; everything is gated low while in reset.
  always_comb begin
    stallF   = 1'b0;
    stall_FD = LOAD;
    stall_DE = LOAD;
    stall_EM = LOAD;
    stall_MW = LOAD;
    if (rst) begin
      if (mem_stall) begin
        stallF   = 1'b1;
        stall_FD = HOLD;
        stall_DE = HOLD;
        stall_EM = HOLD;
        stall_MW = FLUSH;
      end else if (div_hold) begin
        stallF   = 1'b1;
        stall_FD = HOLD;
        stall_DE = HOLD;
        stall_EM = FLUSH;
      end else if (lu) begin
        stallF   = 1'b1;
        stall_FD = HOLD;
        stall_DE = FLUSH;
      end else if (PCSrcD) begin
        stall_FD = FLUSH;
      end
    end
  end

  assign div_done    = rst & div_release;
  assign mem_timeout = rst & mem_stall & (wait_cnt_reg == WCW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    if (state_reg == RUN) begin
      if (div_startE) begin
        state_next   = DIV_BUSY;
        div_cnt_next = DCW'(DIV_CYCLES - 2);
      end
    end else begin
      // Counter keeps running through memory stalls; only the release waits.
      if (div_cnt_reg != '0)
        div_cnt_next = div_cnt_reg - 1'b1;
      if (div_release)
        state_next = RUN;
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (mem_stall)
      wait_cnt_next = (wait_cnt_reg == WCW'(MEM_TIMEOUT)) ? wait_cnt_reg
                                                          : wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      div_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      stall_cycles <= '0;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      if (stallF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (DIV_CYCLES=8, MEM_TIMEOUT=64).
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemtoRegE, RegWriteE, PCSrcD, div_startE, mem_accM, dmem_ready;
  logic [4:0]  WriteRegE, RsD, RtD;
  logic        stallF, div_done, mem_timeout;
  logic [1:0]  stall_FD, stall_DE, stall_EM, stall_MW;
  logic [31:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  localparam logic [8:0] C_NONE = 9'b0_00_00_00_00;
  localparam logic [8:0] C_MEM  = 9'b1_11_11_11_01;
  localparam logic [8:0] C_DIV  = 9'b1_11_11_01_00;
  localparam logic [8:0] C_LU   = 9'b1_11_01_00_00;
  localparam logic [8:0] C_BR   = 9'b0_01_00_00_00;

  logic [8:0] codes;
  assign codes = {stallF, stall_FD, stall_DE, stall_EM, stall_MW};

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(8), .MEM_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .WriteRegE(WriteRegE),
    .RsD(RsD), .RtD(RtD), .PCSrcD(PCSrcD), .div_startE(div_startE),
    .mem_accM(mem_accM), .dmem_ready(dmem_ready),
    .stallF(stallF), .stall_FD(stall_FD), .stall_DE(stall_DE),
    .stall_EM(stall_EM), .stall_MW(stall_MW),
    .div_done(div_done), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0; RsD = 0; RtD = 0;
    PCSrcD = 0; div_startE = 0; mem_accM = 0; dmem_ready = 1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sc0;
    int pulses, pulse_at, bad;

    clear_inputs();
    rst = 0;
    mem_accM = 1; dmem_ready = 0; PCSrcD = 1;
    #2;
    chk("reset_codes", 32'(codes), 32'(C_NONE));
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    tick(); tick();
    rst = 1;
    clear_inputs();
    #1;
    chk("idle_codes", 32'(codes), 32'(C_NONE));

    // Load-use on Rs, then on Rt, then disqualified variants
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5; #1;
    chk("lu_rs", 32'(codes), 32'(C_LU));
    tick();
    chk("lu_stall_cycles", stall_cycles, 32'd1);
    WriteRegE = 0; RsD = 0; #1;
    chk("lu_r0", 32'(codes), 32'(C_NONE));
    WriteRegE = 7; RsD = 5; RtD = 7; #1;
    chk("lu_rt", 32'(codes), 32'(C_LU));
    RegWriteE = 0; #1;
    chk("lu_no_regwrite", 32'(codes), 32'(C_NONE));
    tick();

    // Branch alone, then branch under load-use
    clear_inputs(); PCSrcD = 1; #1;
    chk("branch", 32'(codes), 32'(C_BR));
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9; #1;
    chk("branch_vs_lu", 32'(codes), 32'(C_LU));
    tick();

    // Divide: 7 hold cycles, div_startE held high to show it is ignored while busy
    clear_inputs();
    sc0 = stall_cycles;
    div_startE = 1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("div_hold_%0d", i), {div_done, 23'd0, codes}, {1'b0, 23'd0, C_DIV});
      tick();
    end
    div_startE = 0; #1;
    chk("div_release_codes", 32'(codes), 32'(C_NONE));
    chk("div_release_done", 32'(div_done), 32'd1);
    tick();
    chk("div_stall_cycles", stall_cycles - sc0, 32'd7);
    chk("div_done_cleared", 32'(div_done), 32'd0);

    // Memory wait for 3 cycles; mid-wait the lower-priority sources are also raised
    mem_accM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3; PCSrcD = 1;
      end else begin
        MemtoRegE = 0; PCSrcD = 0;
      end
      #1;
      chk($sformatf("mem_wait_%0d", i), 32'(codes), 32'(C_MEM));
      tick();
    end
    clear_inputs(); mem_accM = 1; dmem_ready = 1; #1;
    chk("mem_ready", 32'(codes), 32'(C_NONE));
    tick();

    // Long wait: exactly one timeout pulse, on the 64th wait cycle
    dmem_ready = 0;
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 70; i++) begin
      #1;
      if (mem_timeout) begin
        pulses++;
        pulse_at = i;
      end
      tick();
    end
    chk("timeout_pulses", 32'(pulses), 32'd1);
    chk("timeout_cycle", 32'(pulse_at), 32'd64);
    dmem_ready = 1; mem_accM = 0;
    tick();

    // Memory wait overlapping the divide's last count: release deferred
    div_startE = 1;
    tick();
    div_startE = 0;
    for (int i = 1; i < 7; i++) tick();
    mem_accM = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ovl_mem_%0d", i), {div_done, 23'd0, codes}, {1'b0, 23'd0, C_MEM});
      tick();
    end
    dmem_ready = 1; #1;
    chk("ovl_codes", 32'(codes), 32'(C_NONE));
    chk("ovl_div_done", 32'(div_done), 32'd1);
    tick();
    clear_inputs(); #1;
    chk("ovl_done_cleared", 32'(div_done), 32'd0);

    // Reset while div_cnt=3 abandons the divide
    div_startE = 1;
    tick();
    div_startE = 0;
    for (int i = 1; i < 4; i++) tick();
    chk("rst_pre_div_hold", 32'(codes), 32'(C_DIV));
    rst = 0; #1;
    chk("rst_mid_div_codes", 32'(codes), 32'(C_NONE));
    tick();
    rst = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (div_done !== 1'b0 || codes !== C_NONE) bad++;
      tick();
    end
    chk("rst_after_idle", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
